// File: rtl/code_serializer.sv
// Digit-to-code serializer: 4-bit digits are mapped to 5-bit codes on push, queued in a
// small FIFO, and sent as 8-bit-time frames (start, 5 data LSB first, even parity, stop).
module code_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3:0]               in_digit,
  output logic                     in_ready,
  input  logic                     ser_en,
  output logic                     ser_data,
  output logic                     ser_busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [4:0]      shreg_q, shreg_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_done_q, frame_done_d;

  logic [4:0]      mem [DEPTH];
  logic            push;
  logic            pop;
  logic [4:0]      push_code;

  // Readiness comes from the registered occupancy only, so it never depends on this cycle's pop.
  assign in_ready  = (count_q < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign push_code = in_digit[3] ? ({1'b0, in_digit} + 5'd14)
                                 : ({1'b0, in_digit} + 5'd3);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      shreg_q      <= 5'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ser_en) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (ser_en) begin
          if (idx_q == 3'd4) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (ser_en) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // A queued code chains straight into the next start bit with no idle gap.
        if (ser_en) begin
          frame_done_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    shreg_d  = shreg_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      shreg_d  = mem[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ser_data = 1'b1;
    ser_busy = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        ser_data = 1'b1;
        ser_busy = 1'b0;
      end
      S_START:  ser_data = 1'b0;
      S_DATA:   ser_data = shreg_q[idx_q];
      S_PARITY: ser_data = ^shreg_q;
      S_STOP:   ser_data = 1'b1;
      default: begin
        ser_data = 1'b1;
        ser_busy = 1'b0;
      end
    endcase
  end

  assign frame_done = frame_done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_code_serializer.sv
// Self-checking bench for code_serializer: vector table, hand-written corner sequences
// and randomized traffic compared against a queue-based frame model.
module tb_code_serializer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    in_digit = 4'd0;
  logic          in_ready;
  logic          ser_en = 1'b0;
  logic          ser_data;
  logic          ser_busy;
  logic          frame_done;
  logic [CW-1:0] count_w;

  int n_checks = 0;
  int n_errors = 0;

  code_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_digit   (in_digit),
    .in_ready   (in_ready),
    .ser_en     (ser_en),
    .ser_data   (ser_data),
    .ser_busy   (ser_busy),
    .frame_done (frame_done),
    .count      (count_w)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending codes and the list of bits still to send.
  int mq[$];
  bit fb[$];
  bit m_fd = 1'b0;

  function automatic logic [4:0] to_code(input logic [3:0] d);
    int v;
    v = (d < 8) ? int'(d) + 3 : int'(d) + 14;
    return 5'(v);
  endfunction

  function automatic void load_frame(input int c);
    logic [4:0] cc;
    cc = 5'(c);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < 5; i++) fb.push_back(cc[i]);
    fb.push_back(^cc);
    fb.push_back(1'b1);
  endfunction

  function automatic void model_edge(input logic v, input logic [3:0] d, input logic en);
    bit rdy;
    rdy  = (mq.size() < DEPTH);
    m_fd = 1'b0;
    if (fb.size() == 0) begin
      if (mq.size() > 0) load_frame(mq.pop_front());
    end else if (en) begin
      void'(fb.pop_front());
      if (fb.size() == 0) begin
        m_fd = 1'b1;
        if (mq.size() > 0) load_frame(mq.pop_front());
      end
    end
    if (v && rdy) mq.push_back(int'(to_code(d)));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic en);
    logic [6:0] got_v, exp_v;
    logic       m_data;
    in_valid = v;
    in_digit = d;
    ser_en   = en;
    model_edge(v, d, en);
    @(posedge clk);
    #1;
    m_data = (fb.size() > 0) ? fb[0] : 1'b1;
    got_v  = {ser_data, ser_busy, frame_done, in_ready, count_w};
    exp_v  = {m_data, 1'(fb.size() > 0), m_fd, 1'(mq.size() < DEPTH), CW'(mq.size())};
    chk("cycle_model", 32'(got_v), 32'(exp_v));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({ser_data, ser_busy, frame_done, in_ready, count_w}),
        32'({1'b1, 1'b0, 1'b0, 1'b1, CW'(0)}));
    mq.delete();
    fb.delete();
    m_fd = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [3:0] d, input int p, input logic [0:7] exp,
                           output logic [0:7] got);
    step(1'b1, d, 1'b0);
    chk("latency_hold", 32'({ser_data, ser_busy, count_w}), 32'({1'b1, 1'b0, CW'(1)}));
    step(1'b0, 4'd0, 1'b0);
    chk("latency_start", 32'({ser_data, ser_busy, count_w}), 32'({1'b0, 1'b1, CW'(0)}));
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < p; k++) begin
        if (k == 0) got[b] = ser_data;
        chk("frame_bit", 32'({frame_done, ser_data}), 32'({1'b0, exp[b]}));
        step(1'b0, 4'd0, 1'(k == p - 1));
      end
    end
    chk("frame_end", 32'({frame_done, ser_busy, ser_data, count_w}),
        32'({1'b1, 1'b0, 1'b1, CW'(0)}));
    step(1'b0, 4'd0, 1'b0);
    chk("done_pulse", 32'(frame_done), 32'(0));
    $display("frame digit=%0d period=%0d bits=%b", d, p, got);
  endtask

  typedef struct {
    logic [3:0] digit;
    int         period;
    logic [0:7] bits;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [0:7] got;
    logic [0:7] expb;
    logic [4:0] c;
    int         nfd;
    int         nrand;

    tbl[0] = '{digit: 4'd0,  period: 1, bits: 8'b0110_0001};
    tbl[1] = '{digit: 4'd8,  period: 1, bits: 8'b0011_0111};
    tbl[2] = '{digit: 4'd15, period: 4, bits: 8'b0101_1101};
    tbl[3] = '{digit: 4'd7,  period: 2, bits: 8'b0010_1001};
    tbl[4] = '{digit: 4'd5,  period: 3, bits: 8'b0000_1011};
    tbl[5] = '{digit: 4'd12, period: 1, bits: 8'b0010_1111};

    #1;
    chk("reset_state", 32'({ser_data, ser_busy, frame_done, in_ready, count_w}),
        32'({1'b1, 1'b0, 1'b0, 1'b1, CW'(0)}));
    #7 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].digit, tbl[i].period, tbl[i].bits, got);
      chk("table_frame", 32'(got), 32'(tbl[i].bits));
    end

    for (int d = 0; d < 16; d++) begin
      c    = to_code(4'(d));
      expb = {1'b0, c[0], c[1], c[2], c[3], c[4], ^c, 1'b1};
      run_frame(4'(d), 1, expb, got);
      chk("payload", 32'({got[5], got[4], got[3], got[2], got[1]}), 32'(c));
      chk("parity", 32'(got[6]), 32'(^c));
    end

    // Six pushes while the line is stalled: one in flight, four queued, one dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 1), 1'b0);
    chk("fill_count", 32'({in_ready, ser_busy, count_w}), 32'({1'b0, 1'b1, CW'(4)}));
    nfd = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'd0, 1'b1);
      if (frame_done) nfd++;
      if (i < 39) chk("back2back_busy", 32'(ser_busy), 32'(1));
    end
    chk("five_frames", 32'(nfd), 32'(5));
    chk("drain_idle", 32'({ser_busy, count_w}), 32'({1'b0, CW'(0)}));
    $display("overflow sequence: %0d frames", nfd);

    for (int i = 0; i < 4; i++) step(1'b1, 4'(9 + i), 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk("mid_data_queued", 32'({ser_busy, count_w}), 32'({1'b1, CW'(3)}));
    do_reset();
    nfd = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'd0, 1'b1);
      if (frame_done || ser_busy) nfd++;
    end
    chk("no_frames_after_reset", 32'(nfd), 32'(0));
    $display("mid-frame reset sequence done");

    nrand = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step(1'($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
      if (m_fd) begin
        nrand++;
        $display("random frame %0d done at cycle %0d", nrand, i);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
